// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// the hardwired-zero register index and the load-use detection helper.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_MEMWAIT = 2'd1,
      S_ERROR   = 2'd2
   } hazard_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
   function automatic logic load_use(input logic       exMemRead,
                                     input logic [4:0] exRt,
                                     input logic [4:0] idRs,
                                     input logic [4:0] idRt,
                                     input logic       idUsesRt);
      return exMemRead && (exRt != REG_ZERO) &&
             ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module pipeline_hazard_ctrl_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: load-use bubbles,
// wrong-path squashing on redirects, and supervised data-memory freezes.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rt,
   input  logic             redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_src,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   hazard_state_e     state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              err_q;

   logic freeze;
   logic luHazard;
   logic active;
   logic stallInc;
   logic flushInc;

   // A dropped mem_req in S_MEMWAIT counts as ready, hence no state term beyond "not in error".
   assign freeze   = mem_req && !mem_ready && (state_q != S_ERROR);
   assign luHazard = load_use(ex_MemRead, ex_rt, id_rs, id_rt, id_uses_rt);
   assign active   = !RST && (state_q != S_ERROR) && !freeze;
   assign stallInc = active && !redirect && luHazard;
   assign flushInc = active && redirect;

   // Mealy control: redirect outranks load-use, and the wrong-path flush also kills the bubble slot.
   always_comb begin
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_write  = 1'b0;
      idex_flush  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      if (active) begin
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         memwb_write = 1'b1;
         if (redirect) begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (luHazard) begin
            idex_flush = 1'b1;
         end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
         end
      end
   end

   // wait_cnt tracks frozen cycles so far; the freeze entering S_MEMWAIT is the first.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_RUN;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (freeze) begin
                  state_q    <= S_MEMWAIT;
                  wait_cnt_q <= WAIT_W'(1);
               end
            end
            S_MEMWAIT: begin
               if (freeze) begin
                  if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                  end else begin
                     wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                  end
               end else begin
                  state_q    <= S_RUN;
                  wait_cnt_q <= '0;
               end
            end
            S_ERROR: begin
               err_q <= 1'b1;
            end
            default: begin
               state_q    <= S_RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   assign err_timeout = err_q;

   pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (stallInc),
      .count (stall_count)
   );

   pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (flushInc),
      .count (flush_count)
   );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/freeze sequencer for the 5-stage MIPS pipeline; it sits beside the ID, EXECUTE and MEM stages.
- Detects load-use hazards that forwarding cannot cover.
- Squashes wrong-path instructions on taken branches and jumps.
- Freezes the whole pipeline while data memory is not ready, with timeout supervision.
- Exposes saturating stall and flush statistics counters.

Parameters:
TIMEOUT, 16, maximum consecutive memory not-ready cycles tolerated before error (>=2)
CNT_W, 16, width of statistics counters

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_MemRead  in  1  EX stage instruction is a load
ex_rt  in  5  destination (rt) of EX stage load
redirect  in  1  taken branch or jump resolved in EX/MEM; PC must load target
mem_req  in  1  MEM stage has MemRead or MemWrite active
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register enable
pc_src  out  1  1 = PC loads redirect target
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear to NOP
idex_write  out  1  ID/EX enable
idex_flush  out  1  ID/EX clear to bubble (all control zero)
exmem_write  out  1  EX/MEM enable
memwb_write  out  1  MEM/WB enable
err_timeout  out  1  sticky memory timeout error
stall_count  out  CNT_W  load-use bubbles inserted, saturating
flush_count  out  CNT_W  redirects applied, saturating

Behaviour:
- FSM states: S_RUN, S_MEMWAIT, S_ERROR. Registered state; control outputs are combinational (Mealy) from state and inputs.
- RST=1:
  - At the edge: state<=S_RUN, wait_cnt<=0, err_timeout<=0, both counters<=0.
  - During the RST cycle: all *_write=0, all flushes=0, pc_src=0.
- Freeze condition, F = (mem_req & !mem_ready) in S_RUN or S_MEMWAIT:
  - All *_write=0, flushes=0, pc_src=0.
  - No counter updates.
  - redirect and load-use are ignored this cycle. They are re-evaluated after release because the stage registers hold.
- S_RUN, no F:
  - Redirect (priority over load-use): pc_write=1, pc_src=1, ifid_flush=1, idex_flush=1, all other writes=1; flush_count+1.
  - Load-use, LU = ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)):
    - pc_write=0, ifid_write=0, idex_flush=1.
    - idex_write, exmem_write and memwb_write=1.
    - stall_count+1. Exactly one bubble per load.
  - Otherwise: all writes=1, flushes=0, pc_src=0.
- Transitions:
  - S_RUN & F -> S_MEMWAIT, wait_cnt<=1.
  - S_MEMWAIT & F: if wait_cnt==TIMEOUT-1 then S_ERROR and err_timeout<=1; else wait_cnt+1.
  - S_MEMWAIT & mem_ready: outputs as in S_RUN (normal/redirect/LU rules), next S_RUN, wait_cnt<=0.
  - mem_req dropping in S_MEMWAIT is treated as ready.
- S_ERROR: all writes=0, flushes=0, err_timeout=1. Exits only via RST.
- Net effect: at most TIMEOUT consecutive frozen cycles before error.
- Counters saturate at all-ones and never wrap.
- id_rs/id_rt compare against ex_rt only; register 0 never causes a stall.

Decomposition:
- Shared package/header (alongside Opcode.vh/ALUop.vh), new Hazard.vh: state encodings S_RUN=2'd0, S_MEMWAIT=2'd1, S_ERROR=2'd2; REG_ZERO=5'd0.
- One natural sub-module: sat_counter (parameter W; ports CLK, RST, inc, count). Instantiated twice for stall_count and flush_count.

Test Plan:
- Load-use:
  - Stimulus: ex_MemRead=1, ex_rt=5, id_rs=5, one cycle.
  - Required: pc_write=0, ifid_write=0, idex_flush=1, stall_count 0->1.
  - Repeat with ex_rt=0: no stall.
- Redirect with LU in the same cycle:
  - Stimulus: redirect=1 and LU=1.
  - Required: pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1, flush_count=1, stall_count unchanged.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - Required: all writes=0 for 3 cycles; the ready cycle has all writes=1; state returns to S_RUN; no error.
- Timeout:
  - Stimulus: TIMEOUT=16, mem_req=1, mem_ready never asserted.
  - Required: err_timeout=1 after the 16th frozen cycle and stays high; writes remain 0; mem_ready=1 does not clear it; RST clears it.
- Reset mid-operation:
  - Stimulus: RST=1 during S_MEMWAIT with counters at 7/3.
  - Required: next cycle S_RUN; counters 0; err_timeout=0.
- Saturation:
  - Stimulus: CNT_W=4, 20 load-use events.
  - Required: stall_count holds 15.
